// File: rtl/xmx_fifo_pkg.sv
// Shared FIFO helpers: mode string constants and pointer/count width functions.
// Ports: none (package).
// Imported by syn_fifo and syn_fifo_ram.
package xmx_fifo_pkg;

  // Read-mode selector strings accepted by the FWFT parameter.
  localparam string FWFT_TRUE  = "TRUE";
  localparam string FWFT_FALSE = "FALSE";

  // Ceiling log2; log2(1) = 0.
  function automatic int log2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Address bits needed to index a storage array of 'depth' words.
  function automatic int addr_w(input int depth);
    return log2(depth);
  endfunction

  // Pointer / count width: one extra bit so 0..depth is representable and
  // full can be told apart from empty by the wrap bit.
  function automatic int ptr_w(input int depth);
    return log2(depth) + 1;
  endfunction

endpackage

// File: rtl/syn_fifo_ram.sv
// Simple dual-port RAM for syn_fifo: one write port, one read port.
// Ports: i_clk, i_rst (clears read register only), write en/addr/data,
//        read en/addr, o_rd_data (registered, one cycle after i_rd_en, holds otherwise).
module syn_fifo_ram #(
  parameter int WIDTH = 32,
  parameter int AW    = 9
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  localparam int NWORDS = 1 << AW;

  // Storage array is deliberately not reset so it can map onto block RAM.
  logic [WIDTH-1:0] mem_q [NWORDS];
  logic [WIDTH-1:0] rd_q;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      mem_q[i_wr_addr] <= i_wr_data;
    end
  end

  // Output register is reset so the FIFO read data starts at zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_q <= '0;
    end else if (i_rd_en) begin
      rd_q <= mem_q[i_rd_addr];
    end
  end

  assign o_rd_data = rd_q;

endmodule

// File: rtl/syn_fifo.sv
// Single-clock FIFO with standard or first-word-fall-through read mode,
// full-range occupancy count (0..DEPTH, so one bit wider than the address),
// almost-full/empty watermarks and sticky overflow/underflow flags.
// Ports: i_clk, i_rst (sync, active-high); write side i_wr_en/i_wr_data,
//        o_full/o_almost_full/o_overflow; read side i_rd_en, o_rd_data/o_rd_valid,
//        o_empty/o_almost_empty/o_underflow; o_data_cnt.
// Optional: `SYN_FIFO_WATERMARK_EN adds i_wm_clr and o_max_cnt (peak count tracker).
module syn_fifo
  import xmx_fifo_pkg::*;
#(
  parameter int    WIDTH         = 32,
  parameter int    DEPTH         = 512,
  parameter string FWFT          = "FALSE",
  parameter int    ALM_FULL_VAL  = 256,
  parameter int    ALM_EMPTY_VAL = 256
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_wr_en,
  input  logic [WIDTH-1:0]          i_wr_data,
  output logic                      o_full,
  output logic                      o_almost_full,
  output logic                      o_overflow,
  input  logic                      i_rd_en,
  output logic [WIDTH-1:0]          o_rd_data,
  output logic                      o_rd_valid,
  output logic                      o_empty,
  output logic                      o_almost_empty,
  output logic                      o_underflow,
`ifdef SYN_FIFO_WATERMARK_EN
  input  logic                      i_wm_clr,
  output logic [ptr_w(DEPTH)-1:0]   o_max_cnt,
`endif
  output logic [ptr_w(DEPTH)-1:0]   o_data_cnt
);

  localparam int AW = addr_w(DEPTH);
  localparam int PW = ptr_w(DEPTH);
  localparam bit IS_FWFT = (FWFT == FWFT_TRUE);

  localparam logic [PW-1:0] AF_VAL = PW'(ALM_FULL_VAL);
  localparam logic [PW-1:0] AE_VAL = PW'(ALM_EMPTY_VAL);

  // wptr: next slot to write. lptr: logical head of the FIFO (the word the
  // consumer sees next). Both carry a wrap bit above the address.
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] lptr_q, lptr_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          afull_q, afull_d;
  logic          aempty_q, aempty_d;
  logic          ovf_q, unf_q;

  logic          wr_acc, rd_acc;
  logic          ram_rd_en;
  logic [AW-1:0] ram_rd_addr;

  // Acceptance uses registered (pre-edge) flags only, so a same-cycle read
  // never frees a slot for a write at full, nor does a write make a read at
  // empty legal.
  assign wr_acc = i_wr_en & ~full_q;
  assign rd_acc = i_rd_en & ~empty_q;

  assign wptr_d = wptr_q + PW'(wr_acc);
  assign lptr_d = lptr_q + PW'(rd_acc);
  assign cnt_d  = wptr_d - lptr_d;

  assign full_d   = (wptr_d[PW-1] != lptr_d[PW-1]) &&
                    (wptr_d[AW-1:0] == lptr_d[AW-1:0]);
  assign afull_d  = (cnt_d >= AF_VAL);
  assign aempty_d = (cnt_d <= AE_VAL);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wptr_q   <= '0;
      lptr_q   <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      lptr_q   <= lptr_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_q | (i_wr_en & full_q);
      unf_q    <= unf_q | (i_rd_en & empty_q);
    end
  end

  syn_fifo_ram #(
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_ram (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_wr_en   (wr_acc),
    .i_wr_addr (wptr_q[AW-1:0]),
    .i_wr_data (i_wr_data),
    .i_rd_en   (ram_rd_en),
    .i_rd_addr (ram_rd_addr),
    .o_rd_data (o_rd_data)
  );

  generate
    if (IS_FWFT) begin : g_fwft
      // The RAM output register doubles as the prefetch stage. fptr tracks
      // the next RAM word to fetch; hv_q says the register holds the head.
      // The head word's RAM slot stays counted as occupied until it is
      // popped, so the writer can never overwrite it.
      logic [PW-1:0] fptr_q, fptr_d;
      logic          hv_q, hv_d;
      logic          fetch;

      // Only fetch words written on an earlier edge (fptr vs pre-edge wptr),
      // which also avoids a same-address read/write collision.
      assign fetch  = (fptr_q != wptr_q) && (!hv_q || rd_acc);
      assign fptr_d = fptr_q + PW'(fetch);
      assign hv_d   = fetch | (hv_q & ~rd_acc);

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          fptr_q <= '0;
          hv_q   <= 1'b0;
        end else begin
          fptr_q <= fptr_d;
          hv_q   <= hv_d;
        end
      end

      assign ram_rd_en   = fetch;
      assign ram_rd_addr = fptr_q[AW-1:0];
      // Readable means the prefetch register is loaded.
      assign empty_d     = ~hv_d;
      assign o_rd_valid  = hv_q;
    end else begin : g_std
      logic rv_q;

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          rv_q <= 1'b0;
        end else begin
          rv_q <= rd_acc;
        end
      end

      assign ram_rd_en   = rd_acc;
      assign ram_rd_addr = lptr_q[AW-1:0];
      assign empty_d     = (wptr_d == lptr_d);
      assign o_rd_valid  = rv_q;
    end
  endgenerate

`ifdef SYN_FIFO_WATERMARK_EN
  logic [PW-1:0] max_q;

  // Clear reloads the live count rather than zero so the peak stays
  // meaningful while the FIFO is non-empty.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      max_q <= '0;
    end else if (i_wm_clr) begin
      max_q <= cnt_q;
    end else if (cnt_q > max_q) begin
      max_q <= cnt_q;
    end
  end

  assign o_max_cnt = max_q;
`endif

  assign o_full         = full_q;
  assign o_almost_full  = afull_q;
  assign o_overflow     = ovf_q;
  assign o_empty        = empty_q;
  assign o_almost_empty = aempty_q;
  assign o_underflow    = unf_q;
  assign o_data_cnt     = cnt_q;

endmodule
